// File: rtl/pe_packet_gen_if.sv
// Packet channel from the PE packet generator towards the ready-to-CSP bridge.
// Plain valid/ready: a transfer happens on a rising clock edge with both high.
interface pe_packet_gen_if #(
  parameter int PKT_W = 54
);
  logic             pkt_valid;
  logic             pkt_ready;
  logic [PKT_W-1:0] pkt_data;

  modport master (output pkt_valid, output pkt_data, input  pkt_ready);
  modport slave  (input  pkt_valid, input  pkt_data, output pkt_ready);
endinterface

// File: rtl/pe_packet_gen.sv
// PE packet generator: per job, reads the 5 filter rows and then one ifmap
// window per convolution location per timestep, and emits one packet for each
// read in the format the PE depacketizer expects.
module pe_packet_gen #(
  parameter int         FILTER_WIDTH = 8,
  parameter int         IFMAP_SIZE   = 25,
  parameter int         NUM_LOC      = 21,
  parameter int         NUM_TS       = 2,
  parameter logic       DIRECTION    = 1'b0,
  parameter logic [1:0] X_HOP        = 2'd0,
  parameter logic [1:0] Y_HOP        = 2'd0,
  parameter logic [3:0] PE_NODE      = 4'd0,
  localparam int PW    = 5 * FILTER_WIDTH,
  localparam int PKT_W = 14 + PW,
  localparam int AW    = (NUM_LOC * NUM_TS > 1) ? $clog2(NUM_LOC * NUM_TS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  filt_rd,
  output logic [2:0]            filt_addr,
  input  logic [PW-1:0]         filt_rdata,
  output logic                  ifm_rd,
  output logic [AW-1:0]         ifm_addr,
  input  logic [IFMAP_SIZE-1:0] ifm_rdata,
  pe_packet_gen_if.master       pkt
);

  localparam int LW     = (NUM_LOC > 1) ? $clog2(NUM_LOC) : 1;
  localparam int LOC_PW = PW - IFMAP_SIZE;

  localparam logic [8:0]    HDR      = {DIRECTION, X_HOP, Y_HOP, PE_NODE};
  localparam logic [LW-1:0] LOC_LAST = LW'(NUM_LOC - 1);
  localparam logic          TS_LAST  = 1'(NUM_TS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    F_RD   = 3'd1,
    F_SEND = 3'd2,
    I_RD   = 3'd3,
    I_SEND = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       row_q,   row_d;
  logic [LW-1:0]    loc_q,   loc_d;
  logic             ts_q,    ts_d;
  // cap_q marks that the packet for the current SEND state has been latched
  // into hold_q; before that the packet is assembled from live SRAM data.
  logic             cap_q,   cap_d;
  logic [PKT_W-1:0] hold_q,  hold_d;

  logic [PKT_W-1:0] live_pkt;
  logic [PKT_W-1:0] pkt_data_w;
  logic             pkt_valid_w;

  // Packet as assembled from the SRAM read data of the preceding RD cycle.
  always_comb begin
    live_pkt = '0;
    if (state_q == F_SEND)
      live_pkt = {HDR, 1'b0, 1'b1, row_q + 3'd1, filt_rdata};
    else if (state_q == I_SEND)
      live_pkt = {HDR, ts_q, 1'b0, 3'd0, LOC_PW'(loc_q), ifm_rdata};
  end

  // Next-state, counters and all outputs; one RD cycle per packet, then a
  // SEND state that holds the packet until the downstream handshake.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    loc_d       = loc_q;
    ts_d        = ts_q;
    cap_d       = cap_q;
    hold_d      = hold_q;
    busy        = 1'b0;
    done        = 1'b0;
    filt_rd     = 1'b0;
    filt_addr   = 3'd0;
    ifm_rd      = 1'b0;
    ifm_addr    = '0;
    pkt_valid_w = 1'b0;
    pkt_data_w  = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = F_RD;
          row_d   = 3'd0;
          loc_d   = '0;
          ts_d    = 1'b0;
        end
      end

      F_RD: begin
        busy      = 1'b1;
        filt_rd   = 1'b1;
        filt_addr = row_q;
        cap_d     = 1'b0;
        state_d   = F_SEND;
      end

      F_SEND: begin
        busy        = 1'b1;
        pkt_valid_w = 1'b1;
        pkt_data_w  = cap_q ? hold_q : live_pkt;
        // Latch the packet so it stays put through any back-pressure,
        // independent of what the SRAM output does afterwards.
        hold_d      = pkt_data_w;
        cap_d       = 1'b1;
        if (pkt.pkt_ready) begin
          cap_d = 1'b0;
          if (row_q == 3'd4) begin
            ts_d    = 1'b0;
            loc_d   = '0;
            state_d = I_RD;
          end else begin
            row_d   = row_q + 3'd1;
            state_d = F_RD;
          end
        end
      end

      I_RD: begin
        busy     = 1'b1;
        ifm_rd   = 1'b1;
        ifm_addr = AW'(ts_q) * AW'(NUM_LOC) + AW'(loc_q);
        cap_d    = 1'b0;
        state_d  = I_SEND;
      end

      I_SEND: begin
        busy        = 1'b1;
        pkt_valid_w = 1'b1;
        pkt_data_w  = cap_q ? hold_q : live_pkt;
        hold_d      = pkt_data_w;
        cap_d       = 1'b1;
        if (pkt.pkt_ready) begin
          cap_d = 1'b0;
          if (loc_q != LOC_LAST) begin
            loc_d   = loc_q + 1'b1;
            state_d = I_RD;
          end else begin
            loc_d = '0;
            if (ts_q != TS_LAST) begin
              ts_d    = ts_q + 1'b1;
              state_d = I_RD;
            end else begin
              state_d = FIN;
            end
          end
        end
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and counter registers; reset aborts any job without replay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= 3'd0;
      loc_q   <= '0;
      ts_q    <= 1'b0;
      cap_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      loc_q   <= loc_d;
      ts_q    <= ts_d;
      cap_q   <= cap_d;
      hold_q  <= hold_d;
    end
  end

  assign pkt.pkt_valid = pkt_valid_w;
  assign pkt.pkt_data  = pkt_data_w;

endmodule

// File: tb/tb_pe_packet_gen.sv
// Directed bench for pe_packet_gen: filter and ifmap phases, back-pressure,
// header fields, start held across done, and reset in the middle of a job.
module tb_pe_packet_gen;

  localparam int PKT_W = 54;
  localparam int TOTAL = 47;
  localparam logic [8:0] HDR_EXP = 9'b1_10_01_1001;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done;
  logic        filt_rd;
  logic [2:0]  filt_addr;
  logic [39:0] filt_rdata;
  logic        ifm_rd;
  logic [5:0]  ifm_addr;
  logic [24:0] ifm_rdata;

  pe_packet_gen_if #(.PKT_W(PKT_W)) pif ();

  pe_packet_gen #(
    .FILTER_WIDTH(8), .IFMAP_SIZE(25), .NUM_LOC(21), .NUM_TS(2),
    .DIRECTION(1'b1), .X_HOP(2'd2), .Y_HOP(2'd1), .PE_NODE(4'd9)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .filt_rd(filt_rd), .filt_addr(filt_addr), .filt_rdata(filt_rdata),
    .ifm_rd(ifm_rd), .ifm_addr(ifm_addr), .ifm_rdata(ifm_rdata),
    .pkt(pif)
  );

  initial forever #5 clk = ~clk;

  // Synchronous-read SRAM models: data appears the cycle after the strobe.
  always @(posedge clk) if (filt_rd) filt_rdata <= 40'h0101010101 * (40'(filt_addr) + 40'd1);
  always @(posedge clk) if (ifm_rd)  ifm_rdata  <= 25'(ifm_addr);

  int frd_cnt = 0, ird_cnt = 0, done_cnt = 0, overlap_cnt = 0;
  always @(posedge clk) begin
    if (filt_rd) frd_cnt++;
    if (ifm_rd)  ird_cnt++;
    if (done)    done_cnt++;
  end
  always @(negedge clk) if (filt_rd && ifm_rd) overlap_cnt++;

  int n_checks = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] exp_pkt(input int i);
    int j;
    logic [PKT_W-1:0] p;
    if (i < 5) begin
      p = {HDR_EXP, 1'b0, 1'b1, 3'(i + 1), 40'h0101010101 * 40'(i + 1)};
    end else begin
      j = i - 5;
      p = {HDR_EXP, 1'((j / 21) % 2), 1'b0, 3'd0, 15'(j % 21), 25'(j)};
    end
    return p;
  endfunction

  // Receive n packets (ready normally high); optionally stall one packet.
  task automatic run_job(input int n, input int stall_idx);
    int idx, t, frd0;
    logic [PKT_W-1:0] held;
    idx = 0;
    t   = 0;
    while (idx < n && t < 2000) begin
      @(negedge clk); t++;
      if (pif.pkt_valid) begin
        check("pkt", 64'(pif.pkt_data), 64'(exp_pkt(idx)));
        check("hdr", 64'(pif.pkt_data[53:45]), 64'(HDR_EXP));
        if (idx == 0) check("f1_payload", 64'(pif.pkt_data[39:0]), 64'h0101010101);
        if (idx == 4) begin
          check("f5_payload", 64'(pif.pkt_data[39:0]), 64'h0505050505);
          check("f5_row", 64'(pif.pkt_data[43:40]), 64'hd);
        end
        if (idx == 26) begin
          check("i22_ts", 64'(pif.pkt_data[44]), 64'd1);
          check("i22_loc", 64'(pif.pkt_data[39:25]), 64'd0);
          check("i22_ifm", 64'(pif.pkt_data[24:0]), 64'd21);
        end
        if (idx == 46) begin
          check("ilast_loc", 64'(pif.pkt_data[39:25]), 64'd20);
          check("ilast_ifm", 64'(pif.pkt_data[24:0]), 64'd41);
        end
        if (idx == stall_idx) begin
          pif.pkt_ready = 1'b0;
          frd0 = frd_cnt;
          held = pif.pkt_data;
          repeat (7) begin
            @(negedge clk); t++;
            check("stall_valid", 64'(pif.pkt_valid), 64'd1);
            check("stall_data", 64'(pif.pkt_data), 64'(held));
            check("stall_frd", 64'(filt_rd), 64'd0);
          end
          check("stall_reads", 64'(frd_cnt), 64'(frd0));
          pif.pkt_ready = 1'b1;
        end
        idx++;
        @(negedge clk); t++;
        check("gap_valid", 64'(pif.pkt_valid), 64'd0);
        if (idx < TOTAL)
          check("rd_strobe", 64'({filt_rd, ifm_rd}), (idx < 5) ? 64'd2 : 64'd1);
        if (idx == TOTAL) begin
          check("done_pulse", 64'(done), 64'd1);
          check("busy_fin", 64'(busy), 64'd0);
        end
      end
    end
    check("pkt_count", 64'(idx), 64'(n));
  endtask

  int frd0, ird0, done0;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pif.pkt_ready = 1'b1;
    #1;
    check("rst_valid", 64'(pif.pkt_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", 64'(pif.pkt_data), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle with start low: nothing happens.
    frd0 = frd_cnt; ird0 = ird_cnt;
    repeat (10) @(negedge clk);
    check("idle_reads", 64'(frd_cnt + ird_cnt), 64'(frd0 + ird0));
    check("idle_valid", 64'(pif.pkt_valid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // Job 1: full job with a 7-cycle stall on the 3rd filter packet.
    frd0 = frd_cnt; ird0 = ird_cnt; done0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("j1_busy", 64'(busy), 64'd1);
    check("j1_frd", 64'(filt_rd), 64'd1);
    check("j1_faddr", 64'(filt_addr), 64'd0);
    run_job(TOTAL, 2);
    @(negedge clk);
    check("j1_done_low", 64'(done), 64'd0);
    check("j1_done_cnt", 64'(done_cnt - done0), 64'd1);
    check("j1_frd_cnt", 64'(frd_cnt - frd0), 64'd5);
    check("j1_ird_cnt", 64'(ird_cnt - ird0), 64'd42);

    // Job 2: start held high through the job and across done.
    done0 = done_cnt;
    start = 1'b1;
    run_job(TOTAL, -1);
    @(negedge clk);
    check("j2_idle_busy", 64'(busy), 64'd0);
    check("j2_done_cnt", 64'(done_cnt - done0), 64'd1);
    @(negedge clk);
    check("j3_restart_busy", 64'(busy), 64'd1);
    check("j3_restart_frd", 64'(filt_rd), 64'd1);
    check("j3_restart_faddr", 64'(filt_addr), 64'd0);
    start = 1'b0;

    // Job 3: reset while in I_SEND with loc=5.
    run_job(10, -1);
    @(negedge clk);
    check("abort_valid", 64'(pif.pkt_valid), 64'd1);
    check("abort_loc", 64'(pif.pkt_data[39:25]), 64'd5);
    rst = 1'b1;
    #1;
    check("abort_valid0", 64'(pif.pkt_valid), 64'd0);
    check("abort_data0", 64'(pif.pkt_data), 64'd0);
    check("abort_busy0", 64'(busy), 64'd0);
    check("abort_strobes0", 64'({filt_rd, ifm_rd, done}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    frd0 = frd_cnt; ird0 = ird_cnt;
    repeat (5) @(negedge clk);
    check("abort_no_reads", 64'(frd_cnt + ird_cnt), 64'(frd0 + ird0));
    check("abort_no_valid", 64'(pif.pkt_valid), 64'd0);

    // Job 4: fresh start replays from filter row 1.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("j4_faddr", 64'(filt_addr), 64'd0);
    run_job(6, -1);

    check("no_overlap", 64'(overlap_cnt), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
